xbus_arb: RTL
=============

// Module: xbus_arb
// PURPOSE
//  Two-master arbiter for the xtop data bus. Shares the single data-bus path
//  (address decoder plus regf/prog/pushs/ps2/disp/gpo) between the xctrl
//  controller (master 0) and a DMA engine (master 1). Issues at most one
//  access per cycle. Returns read data registered with 1-cycle latency.
//  Supports locked DMA bursts of bounded length.
// PARAMETERS
//  ADDR_W     32  address width, equal to `ADDR_W
//  DATA_W     32  data width, equal to `DATA_W
//  MAX_BURST  16  max consecutive locked M1 grants (2..255)
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous, active-low reset
//  m0_req     in   1       M0 access request; held until m0_gnt
//  m0_we      in   1       M0 write enable
//  m0_addr    in   ADDR_W  M0 address
//  m0_wdata   in   DATA_W  M0 write data
//  m0_gnt     out  1       M0 access issued this cycle
//  m0_rdata   out  DATA_W  M0 read data
//  m0_rvalid  out  1       M0 read data valid pulse
//  m1_req     in   1       M1 access request; held until m1_gnt
//  m1_lock    in   1       M1 requests bus lock (burst)
//  m1_we      in   1       M1 write enable
//  m1_addr    in   ADDR_W  M1 address
//  m1_wdata   in   DATA_W  M1 write data
//  m1_gnt     out  1       M1 access issued this cycle
//  m1_rdata   out  DATA_W  M1 read data
//  m1_rvalid  out  1       M1 read data valid pulse
//  s_sel      out  1       bus select toward address decoder (data_sel)
//  s_we       out  1       bus write enable
//  s_addr     out  ADDR_W  bus address
//  s_wdata    out  DATA_W  bus write data
//  s_rdata    in   DATA_W  decoder read mux output (combinational)
//  locked     out  1       1 while in LOCKED state
// BEHAVIOUR
//  - rst low forces state IDLE, last=1, burst_cnt=0, m*_rvalid=0, m*_rdata=0.
//    It also forces m*_gnt=0 and s_sel=0 combinationally. An in-flight
//    rvalid is dropped.
//  - Grants are combinational from the registered state and the current
//    requests. At most one of m0_gnt/m1_gnt is high. s_sel = m0_gnt|m1_gnt.
//    s_we/s_addr/s_wdata mux the granted master's signals; they are 0 when
//    there is no grant.
//  - State IDLE: if only one master requests, grant it.
//  - IDLE with both requesting: grant the master != last (round robin).
//    Reset value last=1, so M0 wins the first tie.
//  - On each grant, last <= granted master index.
//  - IDLE -> LOCKED: when m1_gnt && m1_lock. Set burst_cnt <= 1.
//  - State LOCKED: m0_gnt=0. m1_gnt=m1_req. On each m1_gnt, burst_cnt++.
//  - LOCKED -> RELEASE: when m1_lock==0 (sampled that cycle) or
//    burst_cnt==MAX_BURST at a grant. The cycle's M1 grant is still issued.
//  - State RELEASE (1 cycle): M0 has strict priority. Grant M0 if m0_req,
//    otherwise grant M1 if m1_req (lock ignored). Then -> IDLE.
//    burst_cnt <= 0.
//  - LOCKED with m1_req=0 and m1_lock=1: stay LOCKED with no grant; M0 waits.
//  - Read return: on a grant with we=0, the edge captures s_rdata into
//    mX_rdata, and mX_rvalid=1 for exactly the next cycle.
//  - Writes produce no rvalid. mX_rdata holds its value until the next read
//    by the same master.
//  - Back-to-back reads by one master give one rvalid per grant, in order.
//  - Requests must stay stable until their grant. Dropping a request before
//    its grant is legal; no access is issued for it.
//  - burst_cnt width: $clog2(MAX_BURST+1). It saturates at MAX_BURST and
//    never wraps.
// TESTING
//  - Reset: hold rst=0 with m0_req=m1_req=1 -> gnt=0, s_sel=0, rvalid=0.
//    After release, first tie -> m0_gnt.
//  - Round robin: both req stay high for 4 cycles, lock=0 -> grants
//    M0,M1,M0,M1 and s_addr alternates to match.
//  - Read latency: M1 reads 0x14 with s_rdata=0xA5 -> m1_gnt at cycle t.
//    m1_rvalid=1 and m1_rdata=0xA5 at t+1. m1_rvalid=0 at t+2.
//  - Burst cap: MAX_BURST=4, M1 req+lock held, M0 req held -> 4 M1 grants.
//    Then RELEASE grants M0, then round robin.
//  - Early unlock: M1 drops lock after 2 grants, M0 waiting -> next grant is
//    M0. locked falls with the RELEASE transition.
//  - Async reset mid-burst: rst low while LOCKED with a read pending ->
//    locked=0 and rvalid=0 immediately. The first post-reset tie goes to M0.

Source files
------------

// File: rtl/xbus_arb.sv
// xbus_arb: two-master arbiter for the xtop data bus.
//
// Master 0 is the xctrl controller. Master 1 is a DMA engine that can lock the bus for
// bursts of up to MAX_BURST consecutive grants. At most one access is issued per cycle.
// Grants are combinational from the registered state and the live requests. Read data
// is captured on the granting edge and returned with a one-cycle rvalid pulse.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   m0_req/we/addr/wdata      master 0 request; held until m0_gnt
//   m0_gnt                    master 0 access issued this cycle
//   m0_rdata, m0_rvalid       master 0 read return (registered)
//   m1_req/lock/we/addr/wdata master 1 request, with burst lock
//   m1_gnt                    master 1 access issued this cycle
//   m1_rdata, m1_rvalid       master 1 read return (registered)
//   s_sel/we/addr/wdata       muxed bus access toward the address decoder
//   s_rdata                   decoder read mux output (combinational)
//   locked                    high while a locked M1 burst owns the bus
module xbus_arb #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic              m1_lock,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rvalid,
  output logic              s_sel,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              locked
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StLocked, StRelease} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            gnt0_raw, gnt1_raw;

  // Saturating increment: the burst counter never wraps.
  assign cnt_inc = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CntW'(1);

  always_comb begin
    gnt0_raw = 1'b0;
    gnt1_raw = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (m0_req && m1_req) begin
          // Round robin: the master not granted last wins the tie.
          gnt0_raw = last_q;
          gnt1_raw = ~last_q;
        end else begin
          gnt0_raw = m0_req;
          gnt1_raw = m1_req;
        end
        if (gnt1_raw && m1_lock) begin
          state_d = StLocked;
          cnt_d   = CntW'(1);
        end
      end
      StLocked: begin
        gnt1_raw = m1_req;
        if (gnt1_raw) cnt_d = cnt_inc;
        // The grant that reaches the cap is still issued, then the bus is released.
        if (!m1_lock || (gnt1_raw && cnt_inc == MaxCnt)) state_d = StRelease;
      end
      StRelease: begin
        // One cycle where M0 has strict priority so a burst cannot starve it.
        gnt0_raw = m0_req;
        gnt1_raw = ~m0_req & m1_req;
        state_d  = StIdle;
        cnt_d    = '0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (gnt0_raw)      last_d = 1'b0;
    else if (gnt1_raw) last_d = 1'b1;
  end

  // Reset blocks grants combinationally so no access leaks while rst is low.
  assign m0_gnt = gnt0_raw & rst;
  assign m1_gnt = gnt1_raw & rst;
  assign s_sel  = m0_gnt | m1_gnt;
  assign locked = (state_q == StLocked);

  always_comb begin
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (m0_gnt) begin
      s_we    = m0_we;
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
    end else if (m1_gnt) begin
      s_we    = m1_we;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read return: capture the decoder output on the granting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      if (m0_gnt && !m0_we) m0_rdata <= s_rdata;
      if (m1_gnt && !m1_we) m1_rdata <= s_rdata;
    end
  end

endmodule
